loop_sdram_scheduler: RTL

//  Per-sample SDRAM access sequencer for the loop board. Sits between the loop datapath and the

---
 rtl/loop_sdram_scheduler_pkg.sv | 23 ++
 rtl/loop_sdram_scheduler_if.sv | 26 ++
 rtl/loop_sdram_scheduler_tick_sync.sv | 22 ++
 rtl/loop_sdram_scheduler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/loop_sdram_scheduler_pkg.sv
// rtl/loop_sdram_scheduler_pkg.sv - shared types and defaults for the loop SDRAM scheduler
package loop_sdram_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD,
    ST_RWAIT,
    ST_ADV
  } state_t;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_CH_LOG2    = 19;
  localparam int DEF_ADDR_W     = 25;
  localparam int DEF_RD_TIMEOUT = 64;
  localparam int SAMPLE_W       = 32;

  // Low bit of channel n inside the packed ch_data bus.
  function automatic int ch_lsb(input int ch);
    return ch * SAMPLE_W;
  endfunction

endpackage

// File: rtl/loop_sdram_scheduler_if.sv
// rtl/loop_sdram_scheduler_if.sv - Avalon-MM master bus between scheduler and SDRAM controller
interface loop_sdram_scheduler_if
  import loop_sdram_scheduler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic [ADDR_W-1:0]   avm_address;
  logic                avm_write_n;
  logic                avm_read_n;
  logic [SAMPLE_W-1:0] avm_writedata;
  logic [SAMPLE_W-1:0] avm_readdata;
  logic                avm_readdatavalid;
  logic                avm_waitrequest;

  modport master (
    output avm_address, avm_write_n, avm_read_n, avm_writedata,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write_n, avm_read_n, avm_writedata,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );

endinterface

// File: rtl/loop_sdram_scheduler_tick_sync.sv
// rtl/loop_sdram_scheduler_tick_sync.sv - audio LR clock synchroniser and rising-edge tick
module loop_sdram_scheduler_tick_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic tick
);

  logic [2:0] sync_q;

  // Two flops for metastability, a third for edge history; tick is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
      tick   <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/loop_sdram_scheduler.sv
// rtl/loop_sdram_scheduler.sv - per-frame SDRAM record/playback sequencer with loop pointer
module loop_sdram_scheduler
  import loop_sdram_scheduler_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CH_LOG2    = DEF_CH_LOG2,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       aud_clk,
  input  logic                       record,
  input  logic                       play,
  input  logic [CH_W-1:0]            ch_sel,
  input  logic [SAMPLE_W-1:0]        wr_sample,
  loop_sdram_scheduler_if.master     avm,
  output logic [NUM_CH*SAMPLE_W-1:0] ch_data,
  output logic [CH_LOG2-1:0]         ptr,
  output logic [CH_LOG2:0]           loop_len,
  output logic                       frame_done,
  output logic                       overrun,
  output logic                       rd_err
);

  localparam int TO_W = $clog2(RD_TIMEOUT);

  state_t                      state, state_nxt;
  logic                        tick;
  logic [CH_W-1:0]             ch_q;
  logic [CH_W-1:0]             rec_ch_q;
  logic [SAMPLE_W-1:0]         wdata_q;
  logic                        rec_l, play_l, rec_prev;
  logic [CH_LOG2-1:0]          ptr_q;
  logic [CH_LOG2:0]            len_q;
  logic [TO_W-1:0]             to_cnt;
  logic [NUM_CH*SAMPLE_W-1:0]  ch_data_q;
  logic                        overrun_q, rd_err_q;

  logic                        defining, rec_start, rec_stop;
  logic                        rd_timeout, rd_done, last_ch;
  logic [CH_LOG2:0]            ptr_inc;

  loop_sdram_scheduler_tick_sync u_tick_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (aud_clk),
    .tick     (tick)
  );

  assign defining   = (len_q == '0);
  assign rec_start  = tick && (state == ST_IDLE) && record && !rec_prev && defining;
  assign rec_stop   = tick && (state == ST_IDLE) && !record && rec_prev && defining;
  assign rd_timeout = !avm.avm_readdatavalid && (to_cnt == TO_W'(RD_TIMEOUT - 1));
  assign rd_done    = avm.avm_readdatavalid || rd_timeout;
  assign last_ch    = (ch_q == CH_W'(NUM_CH - 1));
  assign ptr_inc    = {1'b0, ptr_q} + 1'b1;

  // State register; an asynchronous reset drops any command on the bus at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: optional write, then NUM_CH serial reads, then pointer advance.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (tick) state_nxt = record ? ST_WRITE : (play ? ST_RD : ST_ADV);
      ST_WRITE: if (!avm.avm_waitrequest) state_nxt = play_l ? ST_RD : ST_ADV;
      ST_RD:    if (!avm.avm_waitrequest) state_nxt = ST_RWAIT;
      ST_RWAIT: if (rd_done) state_nxt = last_ch ? ST_ADV : ST_RD;
      ST_ADV:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs decoded from state; address is {channel, ptr} zero-extended.
  always_comb begin
    avm.avm_address   = '0;
    avm.avm_write_n   = 1'b1;
    avm.avm_read_n    = 1'b1;
    avm.avm_writedata = '0;
    frame_done        = 1'b0;
    case (state)
      ST_WRITE: begin
        avm.avm_address   = ADDR_W'({rec_ch_q, ptr_q});
        avm.avm_write_n   = 1'b0;
        avm.avm_writedata = wdata_q;
      end
      ST_RD: begin
        avm.avm_address = ADDR_W'({ch_q, ptr_q});
        avm.avm_read_n  = 1'b0;
      end
      ST_ADV:  frame_done = 1'b1;
      default: ;
    endcase
  end

  // Frame datapath: tick latching, loop definition, read capture, timeout and pointer advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q      <= '0;
      rec_ch_q  <= '0;
      wdata_q   <= '0;
      rec_l     <= 1'b0;
      play_l    <= 1'b0;
      rec_prev  <= 1'b0;
      ptr_q     <= '0;
      len_q     <= '0;
      to_cnt    <= '0;
      ch_data_q <= '0;
      overrun_q <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      if (tick && state != ST_IDLE) overrun_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            rec_l    <= record;
            play_l   <= play;
            rec_prev <= record;
            rec_ch_q <= ch_sel;
            wdata_q  <= wr_sample;
            ch_q     <= '0;
            if (rec_start) ptr_q <= '0;
            if (rec_stop) begin
              len_q <= {1'b0, ptr_q};
              ptr_q <= '0;
            end
          end
        end
        ST_RD: begin
          if (!avm.avm_waitrequest) to_cnt <= '0;
        end
        ST_RWAIT: begin
          if (rd_done) begin
            for (int n = 0; n < NUM_CH; n++) begin
              if (ch_q == CH_W'(n))
                ch_data_q[ch_lsb(n) +: SAMPLE_W] <= avm.avm_readdatavalid ? avm.avm_readdata : '0;
            end
            if (!avm.avm_readdatavalid) rd_err_q <= 1'b1;
            if (!last_ch) ch_q <= ch_q + 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_ADV: begin
          if (!play_l) ch_data_q <= '0;
          if (rec_l || play_l) begin
            if (!defining) begin
              ptr_q <= (ptr_inc == len_q) ? '0 : ptr_inc[CH_LOG2-1:0];
            end else begin
              ptr_q <= ptr_inc[CH_LOG2-1:0];
              if (ptr_inc[CH_LOG2] && rec_l) len_q <= ptr_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ch_data  = ch_data_q;
  assign ptr      = ptr_q;
  assign loop_len = len_q;
  assign overrun  = overrun_q;
  assign rd_err   = rd_err_q;

endmodule
